hex_scan_controller: RTL and testbench



---
 rtl/hex_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_hex_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// hex_scan_controller
// Multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS digits.
// A small register file holds the digit codes, and the scanner visits the
// digits round-robin. Each SCAN_DIV-cycle slot starts with BLANK_CYCLES of
// all-digits-off to avoid ghosting. The decoder output is latched into HEX on
// the last blank cycle, so HEX never moves while a digit is lit.
module hex_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  WR_EN,
    input  logic [IDX_W-1:0]      WR_ADDR,
    input  logic [3:0]            WR_DATA,
    output logic [3:0]            DEC_CODE,
    input  logic [6:0]            DEC_SEG,
    output logic [6:0]            HEX,
    output logic [NUM_DIGITS-1:0] DIG_EN,
    output logic                  SLOT_TICK
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [3:0]            digit_d [NUM_DIGITS];
    logic [3:0]            code_q, code_d;
    logic [6:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  tick_q, tick_d;

    // Write port: out-of-range addresses are dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i];
        end
        if (WR_EN && (32'(WR_ADDR) < NUM_DIGITS)) begin
            digit_d[WR_ADDR] = WR_DATA;
        end
    end

    // Digit register file.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    // Scan sequencer: next state, slot counter, digit index and output drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hex_d   = hex_q;
        tick_d  = 1'b0;

        if (!EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            hex_d   = '1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    hex_d   = '1;
                end
                S_BLANK: begin
                    hex_d = '1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        hex_d   = DEC_SEG;
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d   = '0;
                        hex_d   = '1;
                        state_d = S_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    hex_d   = '1;
                end
            endcase
        end

        dig_d = '1;
        if (state_d == S_DRIVE) begin
            dig_d[idx_d] = 1'b0;
        end

        // Code is taken from the next-state index and next-state register
        // contents, so a write coinciding with a slot advance is reflected
        // immediately and DEC_SEG has settled even with a single blank cycle.
        code_d = digit_d[idx_d];
    end

    // Sequencer and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            hex_q   <= '1;
            dig_q   <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            hex_q   <= hex_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
        end
    end

    assign DEC_CODE  = code_q;
    assign HEX       = hex_q;
    assign DIG_EN    = dig_q;
    assign SLOT_TICK = tick_q;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: 4-digit scanner with a queue of expected
// drive slots consumed by a negedge monitor, plus a 3-digit instance.
module tb_hex_scan_controller;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic       EN    = 1'b0;
    logic       WR_EN = 1'b0;
    logic [1:0] WR_ADDR = '0;
    logic [3:0] WR_DATA = '0;
    logic [3:0] DEC_CODE;
    logic [6:0] DEC_SEG;
    logic [6:0] HEX;
    logic [3:0] DIG_EN;
    logic       SLOT_TICK;

    logic       RST3_N = 1'b1;
    logic       EN3    = 1'b0;
    logic       WR_EN3 = 1'b0;
    logic [1:0] WR_ADDR3 = '0;
    logic [3:0] WR_DATA3 = '0;
    logic [3:0] DEC_CODE3;
    logic [6:0] DEC_SEG3;
    logic [6:0] HEX3;
    logic [2:0] DIG_EN3;
    logic       TICK3;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    typedef struct {
        logic [3:0] mask;
        logic [6:0] hex;
        int         blank;
        int         len;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   in_drive  = 1'b0;
    bit   prev_d3   = 1'b0;
    int   drive_len = 0;
    int   blank_run = 0;

    always #5 CLK = ~CLK;

    // Behavioural active-low gfedcba decoder standing in for the board decoder.
    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign DEC_SEG  = seg7(DEC_CODE);
    assign DEC_SEG3 = seg7(DEC_CODE3);

    hex_scan_controller #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .IDX_W(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .DEC_CODE(DEC_CODE), .DEC_SEG(DEC_SEG), .HEX(HEX),
        .DIG_EN(DIG_EN), .SLOT_TICK(SLOT_TICK)
    );

    hex_scan_controller #(
        .NUM_DIGITS(3), .SCAN_DIV(8), .BLANK_CYCLES(2), .IDX_W(2)
    ) dut3 (
        .CLK(CLK), .RST_N(RST3_N), .EN(EN3), .WR_EN(WR_EN3), .WR_ADDR(WR_ADDR3),
        .WR_DATA(WR_DATA3), .DEC_CODE(DEC_CODE3), .DEC_SEG(DEC_SEG3), .HEX(HEX3),
        .DIG_EN(DIG_EN3), .SLOT_TICK(TICK3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        WR_ADDR = a; WR_DATA = d; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] a, input logic [3:0] d);
        WR_ADDR3 = a; WR_DATA3 = d; WR_EN3 = 1'b1;
        tick();
        WR_EN3 = 1'b0;
    endtask

    task automatic push(input logic [3:0] m, input logic [6:0] h, input int b, input int l);
        exp_t e;
        e.mask = m; e.hex = h; e.blank = b; e.len = l;
        q.push_back(e);
    endtask

    // Returns at the first cycle where DIG_EN newly equals mask.
    task automatic wait_slot(input logic [3:0] mask);
        int n = 0;
        while (DIG_EN == mask && n < 200) begin tick(); n++; end
        while (DIG_EN != mask && n < 200) begin tick(); n++; end
        chk("wait_slot", 32'(DIG_EN), 32'(mask));
    endtask

    task automatic wait3(input bit want_drive);
        int n = 0;
        while (((DIG_EN3 != 3'b111) != want_drive) && n < 200) begin tick(); n++; end
        chk("wait3", 32'(DIG_EN3 != 3'b111), 32'(want_drive));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hex"},  32'(HEX),       32'h7F);
        chk({tag, "_dig"},  32'(DIG_EN),    32'hF);
        chk({tag, "_tick"}, 32'(SLOT_TICK), 32'h0);
        chk({tag, "_code"}, 32'(DEC_CODE),  32'h0);
    endtask

    // Monitor: consumes one expected entry per drive slot and checks every
    // drive cycle, the slot's drive length, the blank run before it, and the
    // frame tick.
    always @(negedge CLK) begin
        if (mon_on) begin
            chk("slot_tick", 32'(SLOT_TICK), 32'(prev_d3));
            prev_d3 = 1'b0;
            if (!RST_N || DIG_EN == 4'b1111) begin
                if (in_drive) begin
                    chk("drive_len", 32'(drive_len), 32'(cur.len));
                    in_drive = 1'b0;
                end
                if (!RST_N || !EN) blank_run = 0;
                else blank_run++;
            end else begin
                if (!in_drive) begin
                    if (q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_drive: got DIG_EN %b expected none", DIG_EN);
                        cur.mask = 4'b1111; cur.hex = 7'h7F; cur.blank = blank_run; cur.len = 0;
                    end else begin
                        cur = q.pop_front();
                    end
                    chk("blank_run", 32'(blank_run), 32'(cur.blank));
                    in_drive  = 1'b1;
                    drive_len = 0;
                    blank_run = 0;
                end
                drive_len++;
                chk("drive_dig", 32'(DIG_EN), 32'(cur.mask));
                chk("drive_hex", 32'(HEX),    32'(cur.hex));
                prev_d3 = (cur.mask == 4'b0111) && (drive_len == 6);
            end
        end
    end

    initial begin
        int n;
        #2;
        RST_N  = 1'b0;
        RST3_N = 1'b0;
        #1;
        chk_reset_outputs("reset");
        mon_on = 1'b1;
        repeat (3) tick();
        RST_N = 1'b1;

        // EN low: display stays dark.
        repeat (20) begin
            tick();
            chk("idle_hex", 32'(HEX),    32'h7F);
            chk("idle_dig", 32'(DIG_EN), 32'hF);
        end

        // DEC_CODE follows a write to the currently indexed digit.
        wr(2'd0, 4'h9);
        tick();
        chk("code_after_wr", 32'(DEC_CODE), 32'h9);
        wr(2'd0, 4'h0);
        wr(2'd1, 4'h1);
        wr(2'd2, 4'h2);
        wr(2'd3, 4'h3);
        tick();
        chk("code_idle", 32'(DEC_CODE), 32'h0);

        // Frame 1, frame 2 (digit 1 rewritten to 4), frame 3 cut in digit 2.
        push(4'b1110, 7'b1000000, 3, 6);
        push(4'b1101, 7'b1111001, 2, 6);
        push(4'b1011, 7'b0100100, 2, 6);
        push(4'b0111, 7'b0110000, 2, 6);
        push(4'b1110, 7'b1000000, 2, 6);
        push(4'b1101, 7'b0011001, 2, 6);
        push(4'b1011, 7'b0100100, 2, 6);
        push(4'b0111, 7'b0110000, 2, 6);
        push(4'b1110, 7'b1000000, 2, 6);
        push(4'b1101, 7'b0011001, 2, 6);
        push(4'b1011, 7'b0100100, 2, 3);
        EN = 1'b1;

        wait_slot(4'b1101);
        wr(2'd1, 4'h4);
        tick();
        chk("code_rewrite", 32'(DEC_CODE), 32'h4);

        wait_slot(4'b1011);
        wait_slot(4'b1011);
        wait_slot(4'b1011);
        tick();
        tick();
        EN = 1'b0;
        tick();
        chk("drop_dig",  32'(DIG_EN),    32'hF);
        chk("drop_hex",  32'(HEX),       32'h7F);
        chk("drop_tick", 32'(SLOT_TICK), 32'h0);
        chk("drop_code", 32'(DEC_CODE),  32'h0);
        repeat (3) tick();

        // Restart from digit 0, then asynchronous reset during digit 1.
        push(4'b1110, 7'b1000000, 3, 6);
        push(4'b1101, 7'b0011001, 2, 2);
        EN = 1'b1;
        wait_slot(4'b1101);
        tick();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_outputs("async");

        push(4'b1110, 7'b1000000, 3, 6);
        push(4'b1101, 7'b1000000, 2, 6);
        push(4'b1011, 7'b1000000, 2, 6);
        push(4'b0111, 7'b1000000, 2, 6);
        tick();
        RST_N = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 300) begin tick(); n++; end
        chk("queue_drained", 32'(q.size()), 32'h0);
        n = 0;
        while (DIG_EN != 4'b1111 && n < 50) begin tick(); n++; end
        EN = 1'b0;
        repeat (4) tick();
        mon_on = 1'b0;

        // Three-digit variant: address 3 is out of range and must be ignored.
        RST3_N = 1'b1;
        wr3(2'd0, 4'h5);
        wr3(2'd1, 4'h6);
        wr3(2'd2, 4'h7);
        wr3(2'd3, 4'h9);
        tick();
        chk("d3_code", 32'(DEC_CODE3), 32'h5);
        EN3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] m;
            logic [6:0] h;
            case (k)
                0: begin m = 3'b110; h = 7'b0010010; end
                1: begin m = 3'b101; h = 7'b0000010; end
                2: begin m = 3'b011; h = 7'b1111000; end
                default: begin m = 3'b110; h = 7'b0010010; end
            endcase
            wait3(1'b1);
            chk("d3_dig", 32'(DIG_EN3), 32'(m));
            chk("d3_hex", 32'(HEX3),    32'(h));
            wait3(1'b0);
            chk("d3_tick", 32'(TICK3), 32'(k == 2));
        end
        EN3 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
